mult_sequencer: RTL and testbench
=================================

# mult_sequencer

Iterative HI/LO multiply unit and its sequencer for the MIPS datapath. It accepts a multiply request from the control unit's `mult_enable` decode and runs a radix-2 shift-add multiply over WIDTH cycles. It holds the result in HI/LO registers and drives a `stall` to the pipeline whenever an instruction needs the unit while a multiply is in flight. HI/LO readout is selected by `sfmux_high`; the control unit's `sf2reg` qualifies reads.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mult_enable`  in  1  multiply request, level held by the pipeline until accepted.
- `sf2reg`  in  1  instruction in decode reads HI or LO (mfhi/mflo).
- `sfmux_high`  in  1  1 selects HI and 0 selects LO on `sf_out`.
- `op_a`  in  WIDTH  multiplicand (rs).
- `op_b`  in  WIDTH  multiplier (rt).
- `mult_signed`  in  1  signed request; present only with `MULT_SIGNED_EN`.
- `busy`  out  1  multiply in progress.
- `stall`  out  1  hold the pipeline front end this cycle.
- `sf_out`  out  WIDTH  selected HI or LO value.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO update.

## Operation
- **States:**
  - IDLE
  - RUN
  - FIX, which exists only with the macro.
- **Reset:**
  - State goes to IDLE.
  - HI, LO, the accumulator and the counter are cleared to 0.
  - `busy`, `stall` and `done` are 0.
  - `sf_out` is 0.
- **IDLE with `mult_enable`=1:**
  - Latch `op_a`.
  - Load the accumulator with {WIDTH+1 zeros, `op_b`}.
  - Set the counter to 0.
  - Go to RUN.
  - `stall` stays 0 in this cycle, because the request is accepted.
- **RUN, each cycle:**
  - If acc[0]=1, add the multiplicand to acc[2W:W], using a W+1-bit add to keep the carry.
  - Then logical-shift the whole accumulator right by 1.
  - Increment the counter.
  - On the iteration where counter = WIDTH-1, write HI=acc[2W-1:W] and LO=acc[W-1:0] from the post-shift value, then go to IDLE (to FIX if signed correction is pending).
- **Accumulator width:** 2W+1 bits. The counter is clog2(WIDTH) bits and does not wrap within an operation.
- **Stall:** `stall = busy & (mult_enable | sf2reg)`. A read or a new multiply that arrives during RUN/FIX is held until the cycle after HI/LO update.
  - A new request is accepted only in IDLE, including the cycle immediately after completion, which allows back-to-back operation.
- **Readout:** `sf_out = sfmux_high ? HI : LO` is combinational from the registers. A read in IDLE returns the last completed result.
- **Reset during RUN/FIX:** the operation is abandoned, HI/LO are cleared, and no `done` pulse is issued.
- **Simultaneous `mult_enable` and `sf2reg` in IDLE:** the read returns the old HI/LO and the multiply starts. The decoder never issues both from one instruction, and the unit needs no priority rule.

## Timing
- The request is sampled at edge E0. `busy`=1 from E0 to E0+WIDTH, so WIDTH cycles.
- HI/LO are updated at edge E0+WIDTH (unsigned) or E0+WIDTH+1 (signed).
- `done` is high for exactly the one cycle following the update.
- Latency from request to readable result: WIDTH cycles unsigned, WIDTH+1 signed.
- No combinational path from `op_a`/`op_b` to any output.

## Configuration
- **`MULT_SIGNED_EN` defined:**
  - The `mult_signed` port exists.
  - On acceptance with `mult_signed`=1, operands are replaced by their magnitudes and the sign XOR is recorded.
  - After RUN, the FIX state negates the 2W-bit product when the signs differ (two's complement over {HI,LO}), then goes to IDLE.
  - `busy` covers FIX.
- **Undefined:**
  - The port is absent.
  - All multiplies are unsigned.
  - The FIX state is not synthesized.

## Structure
- Shared package `mult_pkg`:
  - state enum (IDLE, RUN, FIX)
  - default WIDTH constant
  - counter-width function
- One sub-module, `mult_datapath`. It holds the accumulator, the multiplicand register, the shift-add logic and the optional negate. `mult_sequencer` owns the FSM, counter, stall, HI/LO and the `done` pulse.

## Test plan
- 3 × 5 unsigned: HI=0x00000000 and LO=0x0000000F at edge E0+32, `done` one cycle later, `busy` high for exactly 32 cycles.
- 0xFFFFFFFF × 0xFFFFFFFF unsigned: HI=0xFFFFFFFE, LO=0x00000001.
- `sf2reg`=1, `sfmux_high`=1 held from E0+5: `stall`=1 through E0+32, 0 from the next cycle, with `sf_out`=new HI.
- `rst` at E0+10: IDLE next cycle, HI/LO=0, no `done`. A new request is then accepted normally.
- Back-to-back 7×6 then 2×2 with `mult_enable` held: the second is accepted the cycle after the first update, with LO=42 then LO=4.
- (`MULT_SIGNED_EN`) -3 × 5 signed: HI=0xFFFFFFFF, LO=0xFFFFFFF1 at E0+33, `busy` high for 33 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative HI/LO multiply unit: state encoding,
// default operand width and the iteration-counter width helper.
package mult_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/mult_datapath.sv
// Radix-2 shift-add datapath: multiplicand register, 2W+1-bit accumulator and,
// when MULT_SIGNED_EN is defined, operand magnitude and product negation.
module mult_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic               i_step,
   input  logic [WIDTH-1:0]   i_op_a,
   input  logic [WIDTH-1:0]   i_op_b,
`ifdef MULT_SIGNED_EN
   input  logic               i_abs_a,
   input  logic               i_abs_b,
   input  logic               i_neg,
   output logic [2*WIDTH-1:0] o_fix_prod,
`endif
   output logic [2*WIDTH-1:0] o_step_prod
);

   logic [WIDTH-1:0] r_mcand;
   logic [2*WIDTH:0] r_acc;
   logic [2*WIDTH:0] w_acc_next;
   logic [WIDTH:0]   w_upper;
   logic [WIDTH-1:0] w_a_in;
   logic [WIDTH-1:0] w_b_in;

`ifdef MULT_SIGNED_EN
   assign w_a_in     = i_abs_a ? -i_op_a : i_op_a;
   assign w_b_in     = i_abs_b ? -i_op_b : i_op_b;
   assign o_fix_prod = i_neg ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
`else
   assign w_a_in = i_op_a;
   assign w_b_in = i_op_b;
`endif

   // The upper slice is W+1 bits so the carry of the add survives the shift.
   assign w_upper     = r_acc[0] ? (r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand})
                                 : r_acc[2*WIDTH:WIDTH];
   assign w_acc_next  = {w_upper, r_acc[WIDTH-1:0]} >> 1;
   assign o_step_prod = w_acc_next[2*WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand <= '0;
         r_acc   <= '0;
      end else if (i_load) begin
         r_mcand <= w_a_in;
         r_acc   <= {{(WIDTH+1){1'b0}}, w_b_in};
      end else if (i_step) begin
         r_acc   <= w_acc_next;
      end
   end

endmodule

// File: rtl/mult_sequencer.sv
// HI/LO multiply sequencer: FSM, iteration counter, pipeline stall, HI/LO
// registers and done pulse. Signed support is enabled by MULT_SIGNED_EN.
module mult_sequencer
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mult_enable,
   input  logic             sf2reg,
   input  logic             sfmux_high,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
`ifdef MULT_SIGNED_EN
   input  logic             mult_signed,
`endif
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] sf_out,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);

   state_t             r_state;
   state_t             w_next_state;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic               w_accept;
   logic               w_step;
   logic               w_last;
   logic               w_fix;
   logic               w_fix_pend;
   logic [2*WIDTH-1:0] w_step_prod;
   logic [2*WIDTH-1:0] w_fix_prod;

`ifdef MULT_SIGNED_EN
   logic r_signed_req;
   logic r_neg;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_signed_req <= 1'b0;
         r_neg        <= 1'b0;
      end else if (w_accept) begin
         r_signed_req <= mult_signed;
         r_neg        <= mult_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      end
   end

   assign w_fix_pend = r_signed_req;

   mult_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_accept),
      .i_step      (w_step),
      .i_op_a      (op_a),
      .i_op_b      (op_b),
      .i_abs_a     (mult_signed & op_a[WIDTH-1]),
      .i_abs_b     (mult_signed & op_b[WIDTH-1]),
      .i_neg       (r_neg),
      .o_fix_prod  (w_fix_prod),
      .o_step_prod (w_step_prod)
   );
`else
   assign w_fix_pend = 1'b0;
   assign w_fix_prod = w_step_prod;

   mult_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_accept),
      .i_step      (w_step),
      .i_op_a      (op_a),
      .i_op_b      (op_b),
      .o_step_prod (w_step_prod)
   );
`endif

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      w_last       = 1'b0;
      w_fix        = 1'b0;
      case (r_state)
         IDLE: begin
            if (mult_enable) begin
               w_accept     = 1'b1;
               w_next_state = RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_cnt == CW'(WIDTH-1)) begin
               w_last       = 1'b1;
               w_next_state = w_fix_pend ? FIX : IDLE;
            end
         end
`ifdef MULT_SIGNED_EN
         FIX: begin
            w_fix        = 1'b1;
            w_next_state = IDLE;
         end
`endif
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_done  <= (w_last & ~w_fix_pend) | w_fix;
         if (w_accept)
            r_cnt <= '0;
         else if (w_step && !w_last)
            r_cnt <= r_cnt + 1'b1;
         // Signed requests publish HI/LO only once the sign fix is applied.
         if (w_last && !w_fix_pend)
            {r_hi, r_lo} <= w_step_prod;
         else if (w_fix)
            {r_hi, r_lo} <= w_fix_prod;
      end
   end

   assign busy   = (r_state != IDLE);
   assign stall  = busy & (mult_enable | sf2reg);
   assign done   = r_done;
   assign sf_out = sfmux_high ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed and random multiplies
// against an arithmetic product model; signed cases need MULT_SIGNED_EN.
module tb_mult_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         mult_enable;
   logic         sf2reg;
   logic         sfmux_high;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         mult_signed;
   logic         busy;
   logic         stall;
   logic [W-1:0] sf_out;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;

   mult_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .mult_enable (mult_enable),
      .sf2reg      (sf2reg),
      .sfmux_high  (sfmux_high),
      .op_a        (op_a),
      .op_b        (op_b),
`ifdef MULT_SIGNED_EN
      .mult_signed (mult_signed),
`endif
      .busy        (busy),
      .stall       (stall),
      .sf_out      (sf_out),
      .done        (done)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      longint sa;
      longint sb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      return 64'(sa * sb);
   endfunction

   task automatic read_hilo(output logic [63:0] v);
      sfmux_high = 1'b1;
      #1 v[63:32] = sf_out;
      sfmux_high = 1'b0;
      #1 v[31:0] = sf_out;
   endtask

   // One multiply from IDLE: checks acceptance, busy length, done timing and result.
   task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
      logic [63:0] exp;
      logic [63:0] got;
      logic [31:0] done_lo;
      int lat;
      int bc;
      int dc;
      int di;
      exp = model(a, b, sgn);
      lat = sgn ? W + 1 : W;
      bc = 0; dc = 0; di = -1; done_lo = '0;
      op_a = a; op_b = b; mult_signed = sgn; mult_enable = 1'b1; sfmux_high = 1'b0;
      @(negedge clk);
      check({tag, "_accept_stall"}, {63'b0, stall}, 64'd0);
      @(posedge clk);
      #1 mult_enable = 1'b0;
      for (int k = 0; k < lat + 3; k++) begin
         @(negedge clk);
         if (busy) bc++;
         if (done) begin
            dc++;
            if (di < 0) begin
               di = k;
               done_lo = sf_out;
            end
         end
      end
      check({tag, "_busy_cycles"}, 64'(bc), 64'(lat));
      check({tag, "_done_count"}, 64'(dc), 64'd1);
      check({tag, "_done_cycle"}, 64'(di), 64'(lat));
      check({tag, "_done_lo"}, {32'b0, done_lo}, {32'b0, exp[31:0]});
      read_hilo(got);
      check({tag, "_hi"}, {32'b0, got[63:32]}, {32'b0, exp[63:32]});
      check({tag, "_lo"}, {32'b0, got[31:0]}, {32'b0, exp[31:0]});
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] v;
      logic [63:0] exp;
      logic [31:0] a;
      logic [31:0] b;
      int sc;
      int dc;
      int bc;

      rst = 1'b1; mult_enable = 1'b0; sf2reg = 1'b1; sfmux_high = 1'b0;
      op_a = '0; op_b = '0; mult_signed = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_busy", {63'b0, busy}, 64'd0);
      check("reset_stall", {63'b0, stall}, 64'd0);
      check("reset_done", {63'b0, done}, 64'd0);
      read_hilo(v);
      check("reset_hilo", v, 64'd0);
      sf2reg = 1'b0;
      @(posedge clk);
      #1;

      run_mult(32'd3, 32'd5, 1'b0, "u3x5");
      run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax");
      run_mult(32'd0, 32'hDEAD_BEEF, 1'b0, "uzero");
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = $urandom;
         run_mult(a, b, 1'b0, $sformatf("urand%0d", i));
      end

      // Read held off by stall while a multiply runs.
      a = $urandom | 32'h8000_0000;
      b = $urandom | 32'h8000_0000;
      exp = model(a, b, 1'b0);
      op_a = a; op_b = b; mult_enable = 1'b1; sfmux_high = 1'b0;
      @(posedge clk);
      #1 mult_enable = 1'b0;
      sc = 0;
      for (int k = 0; k <= W + 1; k++) begin
         if (k == 5) begin
            sf2reg = 1'b1;
            sfmux_high = 1'b1;
         end
         @(negedge clk);
         if (stall) sc++;
         if (k == W) begin
            check("rd_stall_release", {63'b0, stall}, 64'd0);
            check("rd_new_hi", {32'b0, sf_out}, {32'b0, exp[63:32]});
         end
         @(posedge clk);
         #1;
      end
      check("rd_stall_cycles", 64'(sc), 64'(W - 5));
      sf2reg = 1'b0; sfmux_high = 1'b0;

      // Reset in the middle of a run.
      op_a = 32'd9; op_b = 32'd11; mult_enable = 1'b1;
      @(posedge clk);
      #1 mult_enable = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", {63'b0, busy}, 64'd0);
      read_hilo(v);
      check("midrst_hilo", v, 64'd0);
      dc = 0; bc = 0;
      for (int k = 0; k < W + 4; k++) begin
         @(negedge clk);
         if (done) dc++;
         if (busy) bc++;
      end
      check("midrst_no_done", 64'(dc), 64'd0);
      check("midrst_idle", 64'(bc), 64'd0);
      @(posedge clk);
      #1;
      run_mult(32'd123, 32'd456, 1'b0, "after_rst");

      // Back-to-back with mult_enable held.
      op_a = 32'd7; op_b = 32'd6; mult_enable = 1'b1; sfmux_high = 1'b0;
      @(posedge clk);
      #1;
      sc = 0; dc = 0;
      for (int k = 0; k <= 2 * W + 3; k++) begin
         if (k == W) begin
            op_a = 32'd2;
            op_b = 32'd2;
         end
         if (k == W + 1) mult_enable = 1'b0;
         @(negedge clk);
         if (k < W && stall) sc++;
         if (done) dc++;
         if (k == W) begin
            check("b2b_first_done", {63'b0, done}, 64'd1);
            check("b2b_first_lo", {32'b0, sf_out}, 64'd42);
            check("b2b_accept_stall", {63'b0, stall}, 64'd0);
         end
         if (k == W + 1) check("b2b_second_busy", {63'b0, busy}, 64'd1);
         if (k == 2 * W + 1) begin
            check("b2b_second_done", {63'b0, done}, 64'd1);
            check("b2b_second_lo", {32'b0, sf_out}, 64'd4);
         end
         @(posedge clk);
         #1;
      end
      check("b2b_stall_cycles", 64'(sc), 64'(W));
      check("b2b_done_count", 64'(dc), 64'd2);

`ifdef MULT_SIGNED_EN
      run_mult(32'hFFFF_FFFD, 32'd5, 1'b1, "s_m3x5");
      run_mult(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_min");
      run_mult(32'hFFFF_FFF0, 32'hFFFF_FFF9, 1'b1, "s_negneg");
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = $urandom;
         run_mult(a, b, 1'b1, $sformatf("srand%0d", i));
      end
      run_mult(32'hFFFF_FFFD, 32'd5, 1'b0, "s_off");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
